// File: rtl/reg_access_arbiter.sv
// Round-robin arbiter giving NREQ requesters one-access-per-cycle use of a shared
// storage register; returns read data with a per-requester valid pulse.
module reg_access_arbiter #(
  parameter int unsigned N    = 32,
  parameter int unsigned NREQ = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid_i,
  input  logic [NREQ-1:0]   req_write_i,
  input  logic [NREQ*N-1:0] req_wdata_i,
  output logic [NREQ-1:0]   req_grant_o,
  output logic              reg_we_o,
  output logic              reg_re_o,
  output logic [N-1:0]      reg_wdata_o,
  input  logic [N-1:0]      reg_rdata_i,
  input  logic              reg_err_i,
  output logic [NREQ-1:0]   rsp_valid_o,
  output logic [N-1:0]      rsp_data_o,
  output logic              err_sticky_o
);

  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic            err_q, err_d;

  logic            found;
  logic [PtrW-1:0] win_idx;
  int unsigned     idx;

  // Scan from the priority pointer, wrapping modulo NREQ (NREQ need not be a power of 2).
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    idx     = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(ptr_q) + k) % NREQ;
      if (!found && req_valid_i[idx]) begin
        found   = 1'b1;
        win_idx = PtrW'(idx);
      end
    end
  end

  always_comb begin
    req_grant_o = '0;
    reg_we_o    = 1'b0;
    reg_re_o    = 1'b0;
    reg_wdata_o = '0;
    ptr_d       = ptr_q;
    rsp_valid_d = '0;
    err_d       = err_q | reg_err_i;
    if (found && !reset) begin
      req_grant_o[win_idx] = 1'b1;
      ptr_d = (32'(win_idx) == NREQ - 1) ? '0 : win_idx + PtrW'(1);
      if (req_write_i[win_idx]) begin
        reg_we_o    = 1'b1;
        reg_wdata_o = req_wdata_i[32'(win_idx)*N +: N];
      end else begin
        reg_re_o             = 1'b1;
        rsp_valid_d[win_idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q       <= '0;
      rsp_valid_q <= '0;
      err_q       <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      err_q       <= err_d;
    end
  end

  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_data_o   = reg_rdata_i;
  assign err_sticky_o = err_q;

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Directed bench for reg_access_arbiter: expected read responses are queued at grant
// time and a negedge monitor checks them against the response port.
module tb_reg_access_arbiter;
  localparam int unsigned N    = 32;
  localparam int unsigned NREQ = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_write = '0;
  logic [NREQ*N-1:0] req_wdata = '0;
  logic [NREQ-1:0]   req_grant;
  logic              reg_we, reg_re;
  logic [N-1:0]      reg_wdata;
  logic [N-1:0]      reg_rdata = '0;
  logic              reg_err;
  logic [NREQ-1:0]   rsp_valid;
  logic [N-1:0]      rsp_data;
  logic              err_sticky;

  logic [N-1:0]      mem = '0;
  logic              err_force = 1'b0;
  logic              rand_mode = 1'b0;
  int                cyc_cnt = 0;
  int                checks = 0;
  int                errors = 0;

  typedef struct {
    int           due;
    int           idx;
    logic [N-1:0] data;
  } exp_t;
  exp_t exp_q[$];

  reg_access_arbiter #(.N(N), .NREQ(NREQ)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid_i  (req_valid),
    .req_write_i  (req_write),
    .req_wdata_i  (req_wdata),
    .req_grant_o  (req_grant),
    .reg_we_o     (reg_we),
    .reg_re_o     (reg_re),
    .reg_wdata_o  (reg_wdata),
    .reg_rdata_i  (reg_rdata),
    .reg_err_i    (reg_err),
    .rsp_valid_o  (rsp_valid),
    .rsp_data_o   (rsp_data),
    .err_sticky_o (err_sticky)
  );

  always #5 clk = ~clk;

  // Behavioural shared register: single write port, registered read port.
  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (reg_we) mem <= reg_wdata;
    if (reg_re) reg_rdata <= mem;
  end
  assign reg_err = err_force | (reg_we & reg_re);

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_out(input string nm, input logic [NREQ-1:0] g, input logic we,
                         input logic re, input logic [N-1:0] wd);
    #1;
    check({nm, "_grant"}, 64'(req_grant), 64'(g));
    check({nm, "_we"}, 64'(reg_we), 64'(we));
    check({nm, "_re"}, 64'(reg_re), 64'(re));
    check({nm, "_wdata"}, 64'(reg_wdata), 64'(wd));
  endtask

  task automatic push_rd(input int idx, input logic [N-1:0] data);
    exp_t e;
    e.due  = cyc_cnt + 1;
    e.idx  = idx;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic set_wdata(input int i, input logic [N-1:0] v);
    req_wdata[i*N +: N] = v;
  endtask

  // Response monitor
  initial begin
    exp_t            e;
    logic [NREQ-1:0] oh;
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("we_re_exclusive", 64'(reg_we & reg_re), 64'd0);
        if (!rand_mode) begin
          while (exp_q.size() > 0 && exp_q[0].due < cyc_cnt) begin
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL rsp_missing: requester %0d got no rsp_valid, expected at cycle %0d",
                     e.idx, e.due);
          end
          if (exp_q.size() > 0 && exp_q[0].due == cyc_cnt) begin
            e  = exp_q.pop_front();
            oh = '0;
            oh[e.idx] = 1'b1;
            check("rsp_valid", 64'(rsp_valid), 64'(oh));
            check("rsp_data", 64'(rsp_data), 64'(e.data));
          end else begin
            check("rsp_idle", 64'(rsp_valid), 64'd0);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Outputs held at zero during reset even with requests pending
    req_valid = 4'hF;
    req_write = 4'h5;
    req_wdata = {NREQ*N{1'b1}};
    #2;
    exp_out("in_reset", 4'h0, 1'b0, 1'b0, '0);
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_err", 64'(err_sticky), 64'd0);
    cyc();
    cyc();
    reset     = 1'b0;
    req_wdata = '0;

    // Write by 0 then read by 1
    req_valid = 4'b0001;
    req_write = 4'b0001;
    set_wdata(0, 32'hDEADBEEF);
    exp_out("wr0", 4'b0001, 1'b1, 1'b0, 32'hDEADBEEF);
    cyc();
    req_valid = 4'b0010;
    req_write = 4'b0000;
    exp_out("rd1", 4'b0010, 1'b0, 1'b1, '0);
    push_rd(1, 32'hDEADBEEF);
    cyc();
    req_valid = '0;
    cyc();
    cyc();

    // Reset to bring ptr back to 0, then all four reading for 8 cycles
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    req_valid = 4'hF;
    req_write = 4'h0;
    for (int i = 0; i < 8; i++) begin
      exp_out("rr_all", 4'(1 << (i % 4)), 1'b0, 1'b1, '0);
      push_rd(i % 4, 32'hDEADBEEF);
      cyc();
    end
    req_valid = '0;
    cyc();
    cyc();

    // Move ptr to 3, then requester 3 read competes with requester 2 write
    req_valid = 4'b0100;
    exp_out("rd2", 4'b0100, 1'b0, 1'b1, '0);
    push_rd(2, 32'hDEADBEEF);
    cyc();
    req_valid = 4'b1100;
    req_write = 4'b0100;
    set_wdata(2, 32'h5);
    exp_out("rd3_first", 4'b1000, 1'b0, 1'b1, '0);
    push_rd(3, 32'hDEADBEEF);
    cyc();
    req_valid = 4'b0100;
    exp_out("wr2_next", 4'b0100, 1'b1, 1'b0, 32'h5);
    cyc();
    req_valid = 4'b1000;
    req_write = 4'b0000;
    exp_out("rd3_new", 4'b1000, 1'b0, 1'b1, '0);
    push_rd(3, 32'h5);
    cyc();
    req_valid = '0;

    // Idle for 5 cycles, ptr must stay at 0
    for (int i = 0; i < 5; i++) begin
      exp_out("idle", 4'h0, 1'b0, 1'b0, '0);
      cyc();
    end
    req_valid = 4'hF;
    exp_out("after_idle", 4'b0001, 1'b0, 1'b1, '0);
    push_rd(0, 32'h5);
    cyc();
    req_valid = '0;
    cyc();
    cyc();

    // Random traffic: exclusivity checked by the monitor, err must stay clear
    rand_mode = 1'b1;
    for (int i = 0; i < 20; i++) begin
      req_valid = 4'($urandom);
      req_write = 4'($urandom);
      for (int j = 0; j < int'(NREQ); j++) set_wdata(j, $urandom);
      #1;
      check("rand_err_clear", 64'(err_sticky), 64'd0);
      cyc();
    end
    req_valid = '0;
    cyc();
    cyc();
    rand_mode = 1'b0;

    // Reset right after a read grant drops the response
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    req_valid = 4'b0010;
    req_write = 4'b0000;
    exp_out("rd1_pre_rst", 4'b0010, 1'b0, 1'b1, '0);
    cyc();
    reset = 1'b1;
    exp_out("mid_rst", 4'h0, 1'b0, 1'b0, '0);
    check("mid_rst_rsp", 64'(rsp_valid), 64'd0);
    cyc();
    reset     = 1'b0;
    req_valid = 4'b1000;
    req_write = 4'b1000;
    set_wdata(3, 32'h12345678);
    exp_out("wr3_post_rst", 4'b1000, 1'b1, 1'b0, 32'h12345678);
    cyc();
    req_valid = 4'b0001;
    req_write = 4'b0000;
    exp_out("rd0_wrap", 4'b0001, 1'b0, 1'b1, '0);
    push_rd(0, 32'h12345678);
    cyc();
    req_valid = '0;
    cyc();
    cyc();

    // Sticky error
    check("err_before", 64'(err_sticky), 64'd0);
    err_force = 1'b1;
    cyc();
    err_force = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("err_sticky", 64'(err_sticky), 64'd1);
      cyc();
    end
    reset = 1'b1;
    #1;
    check("err_cleared", 64'(err_sticky), 64'd0);
    cyc();
    reset = 1'b0;
    cyc();
    cyc();

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
